// File: rtl/row_buf_wr_sequencer.sv
// Write sequencer that streams accepted pixel words into NUM_DEST row buffers
// of ROW_LEN words each, through an external 1-to-NUM_DEST demux.
module row_buf_wr_sequencer #(
    parameter int DATA_W   = 16,
    parameter int NUM_DEST = 29,
    parameter int ROW_LEN  = 29
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic              abort,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              wr_en,
    output logic [4:0]        wr_sel,
    output logic [4:0]        wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              busy,
    output logic              frame_done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [4:0] COL_LAST  = 5'(ROW_LEN - 1);
    localparam logic [4:0] DEST_LAST = 5'(NUM_DEST - 1);

    state_t     state;
    logic [4:0] col_cnt;
    logic [4:0] dest_cnt;
    logic       accept;

    // in_ready is a registered copy of (state == RUN), so this is the accept.
    assign accept = in_valid & in_ready;

    // Frame FSM, position counters and all registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            col_cnt    <= 5'd0;
            dest_cnt   <= 5'd0;
            in_ready   <= 1'b0;
            wr_en      <= 1'b0;
            wr_sel     <= 5'd0;
            wr_addr    <= 5'd0;
            wr_data    <= '0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            wr_en      <= 1'b0;
            frame_done <= 1'b0;
            if (abort) begin
                state    <= IDLE;
                col_cnt  <= 5'd0;
                dest_cnt <= 5'd0;
                in_ready <= 1'b0;
                busy     <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start) begin
                            state    <= RUN;
                            col_cnt  <= 5'd0;
                            dest_cnt <= 5'd0;
                            in_ready <= 1'b1;
                            busy     <= 1'b1;
                        end else begin
                            in_ready <= 1'b0;
                            busy     <= 1'b0;
                        end
                    end
                    RUN: begin
                        if (accept) begin
                            wr_en   <= 1'b1;
                            wr_sel  <= dest_cnt;
                            wr_addr <= col_cnt;
                            wr_data <= in_data;
                            if (col_cnt == COL_LAST) begin
                                col_cnt <= 5'd0;
                                if (dest_cnt == DEST_LAST) begin
                                    // Last word: DONE coincides with its strobe.
                                    state      <= DONE;
                                    dest_cnt   <= 5'd0;
                                    in_ready   <= 1'b0;
                                    frame_done <= 1'b1;
                                end else begin
                                    dest_cnt <= dest_cnt + 5'd1;
                                end
                            end else begin
                                col_cnt <= col_cnt + 5'd1;
                            end
                        end else begin
                            in_ready <= 1'b1;
                        end
                    end
                    DONE: begin
                        state    <= IDLE;
                        in_ready <= 1'b0;
                        busy     <= 1'b0;
                    end
                    default: begin
                        state    <= IDLE;
                        col_cnt  <= 5'd0;
                        dest_cnt <= 5'd0;
                        in_ready <= 1'b0;
                        busy     <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_row_buf_wr_sequencer.sv
// Randomized scoreboard bench for row_buf_wr_sequencer against a frame-level
// reference model (words accepted so far -> expected destination/address).
module tb_row_buf_wr_sequencer;

    localparam int DATA_W   = 16;
    localparam int NUM_DEST = 29;
    localparam int ROW_LEN  = 29;
    localparam int TOTAL    = NUM_DEST * ROW_LEN;

    logic              clk = 1'b0;
    logic              reset_n = 1'b1;
    logic              start = 1'b0;
    logic              abort = 1'b0;
    logic              in_valid = 1'b0;
    logic [DATA_W-1:0] in_data = '0;
    logic              in_ready;
    logic              wr_en;
    logic [4:0]        wr_sel;
    logic [4:0]        wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              busy;
    logic              frame_done;

    row_buf_wr_sequencer #(
        .DATA_W(DATA_W), .NUM_DEST(NUM_DEST), .ROW_LEN(ROW_LEN)
    ) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .abort(abort),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .wr_en(wr_en), .wr_sel(wr_sel), .wr_addr(wr_addr), .wr_data(wr_data),
        .busy(busy), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]        sel;
        logic [4:0]        addr;
        logic [DATA_W-1:0] data;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model state: frame-level view only.
    bit                m_run = 1'b0;
    bit                m_done = 1'b0;
    int                m_count = 0;
    int                m_frames = 0;
    logic [4:0]        m_sel = 5'd0;
    logic [4:0]        m_addr = 5'd0;
    logic [DATA_W-1:0] m_data = '0;

    int n_strobes = 0;
    int n_done = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: word k of a frame goes to dest k/ROW_LEN, addr k%ROW_LEN.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk or negedge reset_n);
            if (!reset_n) begin
                m_run = 1'b0; m_done = 1'b0; m_count = 0;
                m_sel = 5'd0; m_addr = 5'd0; m_data = '0;
                q.delete();
            end else if (abort) begin
                m_run = 1'b0; m_done = 1'b0; m_count = 0;
            end else if (m_run) begin
                m_done = 1'b0;
                if (in_valid) begin
                    e.sel  = 5'(m_count / ROW_LEN);
                    e.addr = 5'(m_count % ROW_LEN);
                    e.data = in_data;
                    q.push_back(e);
                    m_sel = e.sel; m_addr = e.addr; m_data = e.data;
                    m_count++;
                    if (m_count == TOTAL) begin
                        m_run = 1'b0; m_done = 1'b1; m_frames++;
                    end
                end
            end else if (m_done) begin
                m_done = 1'b0;
            end else if (start) begin
                m_run = 1'b1; m_count = 0;
            end
        end
    end

    // Monitor: compare every cycle, popping an expected strobe when wr_en shows.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            chk("in_ready", 32'(in_ready), 32'(m_run));
            chk("busy", 32'(busy), 32'(m_run | m_done));
            chk("frame_done", 32'(frame_done), 32'(m_done));
            if (wr_en) begin
                if (q.size() == 0) begin
                    chk("unexpected_strobe", 32'(1), 32'(0));
                end else begin
                    e = q.pop_front();
                    chk("wr_sel", 32'(wr_sel), 32'(e.sel));
                    chk("wr_addr", 32'(wr_addr), 32'(e.addr));
                    chk("wr_data", 32'(wr_data), 32'(e.data));
                end
                if (n_strobes == ROW_LEN)
                    chk("row_wrap", {27'd0, wr_sel, wr_addr} >> 0, {22'd0, 5'd1, 5'd0});
                n_strobes++;
            end else begin
                chk("missing_strobe", 32'(q.size()), 32'(0));
                chk("hold_sel", 32'(wr_sel), 32'(m_sel));
                chk("hold_addr", 32'(wr_addr), 32'(m_addr));
                chk("hold_data", 32'(wr_data), 32'(m_data));
            end
            if (frame_done) begin
                n_done++;
                chk("done_strobe", {22'd0, wr_en, wr_sel, wr_addr},
                    {22'd0, 1'b1, 5'(NUM_DEST - 1), 5'(ROW_LEN - 1)});
            end
        end
    end

    task automatic do_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic feed(input int target, input int pct, input int bound);
        int n = 0;
        while (m_count < target && n < bound) begin
            in_valid = ($urandom_range(0, 99) < pct);
            in_data  = DATA_W'(m_count);
            @(negedge clk);
            n++;
        end
        chk("feed_reached", 32'(m_count >= target), 32'(1));
    endtask

    task automatic frame_end(input string name);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk({name, "_strobes"}, 32'(n_strobes), 32'(TOTAL));
        chk({name, "_done_pulses"}, 32'(n_done), 32'(1));
    endtask

    task automatic outputs_zero(input string name);
        chk(name, {20'd0, in_ready, wr_en, wr_sel, wr_addr, busy, frame_done},
            32'd0);
        chk({name, "_data"}, 32'(wr_data), 32'd0);
    endtask

    initial begin
        #1 reset_n = 1'b0;
        repeat (3) @(negedge clk);
        outputs_zero("reset_state");
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        // Full frame, in_valid always high.
        n_strobes = 0; n_done = 0;
        do_start();
        feed(TOTAL, 100, 2000);
        frame_end("full");

        // Full frame with 30% valid duty.
        n_strobes = 0; n_done = 0;
        do_start();
        feed(TOTAL, 30, 20000);
        frame_end("gaps");

        // Second start after 10 accepts is ignored.
        n_strobes = 0; n_done = 0;
        do_start();
        feed(10, 100, 100);
        start = 1'b1; in_valid = 1'b1; in_data = DATA_W'(m_count);
        @(negedge clk);
        start = 1'b0;
        feed(TOTAL, 100, 2000);
        frame_end("restart_ignored");

        // Abort after 100 accepts with in_valid high.
        do_start();
        feed(100, 100, 500);
        abort = 1'b1; in_valid = 1'b1; in_data = DATA_W'(m_count);
        @(posedge clk);
        #1;
        chk("abort_wr_en", 32'(wr_en), 32'(0));
        chk("abort_in_ready", 32'(in_ready), 32'(0));
        chk("abort_busy", 32'(busy), 32'(0));
        @(negedge clk);
        abort = 1'b0; in_valid = 1'b0;
        repeat (2) @(negedge clk);
        n_strobes = 0; n_done = 0;
        do_start();
        feed(TOTAL, 70, 5000);
        frame_end("after_abort");

        // Asynchronous reset between clock edges.
        do_start();
        feed(50, 100, 500);
        @(posedge clk);
        #2 reset_n = 1'b0;
        #1 outputs_zero("async_reset");
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        in_valid = 1'b1;
        repeat (5) @(negedge clk);
        chk("idle_after_reset", 32'(busy), 32'(0));
        in_valid = 1'b0;
        repeat (2) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/row_buf_wr_sequencer.md
ROW_BUF_WR_SEQUENCER -- requirements
Module: row_buf_wr_sequencer

Interface
REQ-001 The block SHALL have parameter DATA_W, default 16, meaning width of the pixel data word.
REQ-002 The block SHALL have parameter NUM_DEST, default 29, meaning number of destination row buffers (legal range 2..32).
REQ-003 The block SHALL have parameter ROW_LEN, default 29, meaning number of words written per destination (legal range 2..32).
REQ-004 The block SHALL have port clk, input, 1 bit, the single clock; all state is updated on its rising edge.
REQ-005 The block SHALL have port reset_n, input, 1 bit, asynchronous active-low reset.
REQ-006 The block SHALL have port start, input, 1 bit, a one-cycle request to begin a frame.
REQ-007 The block SHALL have port abort, input, 1 bit, a synchronous frame cancel.
REQ-008 The block SHALL have port in_valid, input, 1 bit, qualifying in_data as valid.
REQ-009 The block SHALL have port in_data, input, DATA_W bits, the incoming pixel word.
REQ-010 The block SHALL have port in_ready, output, 1 bit, indicating the block can accept a word this cycle.
REQ-011 The block SHALL have port wr_en, output, 1 bit, the write strobe that drives the 1-to-NUM_DEST demux data input.
REQ-012 The block SHALL have port wr_sel, output, 5 bits, the destination index that drives the demux select (0 maps to destination 1).
REQ-013 The block SHALL have port wr_addr, output, 5 bits, the word index within the destination buffer.
REQ-014 The block SHALL have port wr_data, output, DATA_W bits, the word to write.
REQ-015 The block SHALL have port busy, output, 1 bit, high while the state is RUN or DONE.
REQ-016 The block SHALL have port frame_done, output, 1 bit, a one-cycle pulse at frame completion.

Function
REQ-017 The block SHALL implement FSM states IDLE, RUN and DONE, with internal counters col_cnt (0..ROW_LEN-1) and dest_cnt (0..NUM_DEST-1).
REQ-018 In IDLE with start=1 and abort=0, the block SHALL clear both counters and enter RUN at the next edge; start SHALL be ignored in RUN and DONE.
REQ-019 in_ready SHALL be a registered output equal to 1 exactly while the state is RUN.
REQ-020 An accept SHALL occur on any edge where in_valid=1 and in_ready=1; the block SHALL NOT accept in any other cycle.
REQ-021 On an accept, the next cycle SHALL present wr_en=1, wr_sel=dest_cnt, wr_addr=col_cnt and wr_data=in_data; this is a latency of exactly 1 cycle.
REQ-022 In any cycle not preceded by an accept, wr_en SHALL be 0, and wr_sel, wr_addr and wr_data SHALL hold their last values.
REQ-023 On an accept with col_cnt<ROW_LEN-1, col_cnt SHALL increment by 1.
REQ-024 On an accept with col_cnt=ROW_LEN-1, col_cnt SHALL wrap to 0 and dest_cnt SHALL increment by 1.
REQ-025 On an accept with col_cnt=ROW_LEN-1 and dest_cnt=NUM_DEST-1, the block SHALL enter DONE, and in_ready SHALL be 0 in the following cycle.
REQ-026 wr_sel SHALL never exceed NUM_DEST-1 (28 by default), so demux outputs 30..32 are never addressed.
REQ-027 DONE SHALL last exactly one cycle: frame_done=1 during it, and the last write strobe (wr_en=1) coincides with that cycle; the block SHALL then return to IDLE.
REQ-028 abort=1 in any state SHALL force IDLE at the next edge, clear both counters, drive in_ready=0 and frame_done=0, and discard any accept in that same cycle (wr_en=0 next cycle).
REQ-029 abort SHALL take priority over start and over accept when they occur in the same cycle.
REQ-030 in_valid=0 gaps during RUN SHALL stall the counters without limit and without losing position.
REQ-031 Exactly NUM_DEST*ROW_LEN write strobes SHALL be issued per completed frame, in order dest 0..NUM_DEST-1 and, within each dest, addr 0..ROW_LEN-1.

Reset
REQ-032 While reset_n=0 (asynchronous assertion), the block SHALL be in state IDLE, both counters SHALL be 0, and in_ready, wr_en, wr_sel, wr_addr, wr_data, busy and frame_done SHALL all be 0.
REQ-033 Reset asserted mid-frame SHALL abandon the frame; after release, the block SHALL wait in IDLE for a new start.

Verification
REQ-034 The bench SHALL cover a full frame: reset, start pulse, then in_valid held high with in_data=k for k=0..840 -> 841 strobes; strobe k has wr_sel=k/29, wr_addr=k%29 and wr_data=k; frame_done pulses once, in the cycle of the strobe with wr_sel=28 and wr_addr=28.
REQ-035 The bench SHALL cover the row wrap: after 29 accepts, the 30th strobe shows wr_sel=1 and wr_addr=0.
REQ-036 The bench SHALL cover backpressure gaps: a random in_valid pattern at 30% duty over a full frame -> the same strobe sequence as REQ-034, with no duplicates or skips.
REQ-037 The bench SHALL cover abort mid-frame: abort after 100 accepts with in_valid=1 -> wr_en=0 the next cycle, in_ready=0 and busy=0; a new start restarts at wr_sel=0, wr_addr=0.
REQ-038 The bench SHALL cover start ignored in RUN: a second start pulse after 10 accepts -> the counters continue (the 11th strobe has wr_addr=10).
REQ-039 The bench SHALL cover asynchronous reset mid-frame: reset_n low between clock edges -> all outputs go to 0 immediately, without waiting for a clock edge.
